nf_wb_arbiter: RTL and testbench

//  Write-back arbiter sitting directly upstream of the register file write port (wa3/wd3/we3).

---
 rtl/nf_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_nf_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_wb_arbiter.sv
// Write-back arbiter in front of the register file write port: merges in-order pipeline
// results with in-order load returns and stalls decode on registers with loads in flight.
module nf_wb_arbiter #(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        pipe_we,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_wa,
  output logic        ld_issue_rdy,
  input  logic        ld_rvalid,
  input  logic [31:0] ld_rdata,
  output logic        ld_rready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa_dec,
  output logic        lhz_stall,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3
);

  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(LD_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Load-destination queue
  logic       valid_q [LD_DEPTH];
  logic       valid_d [LD_DEPTH];
  logic [4:0] wa_q    [LD_DEPTH];
  logic [4:0] wa_d    [LD_DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q,  count_d;

  // Output register
  logic        we3_q, we3_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;

  logic       pipe_eff;
  logic [4:0] head_wa;
  logic       push;
  logic       pop;

  // Handshake and arbitration: the pipeline always owns the port when it writes a real register.
  always_comb begin
    head_wa      = wa_q[rd_ptr_q];
    pipe_eff     = pipe_we && (pipe_wa != 5'd0);
    ld_issue_rdy = (count_q < cnt_t'(LD_DEPTH));
    ld_rready    = (count_q != '0) && (!pipe_eff || (head_wa == 5'd0));
    pop          = ld_rvalid && ld_rready;
    // A full queue still takes a new load when the head retires in the same cycle.
    push         = ld_issue && (ld_issue_rdy || pop);
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < LD_DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      wa_d[i]    = wa_q[i];
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    // Pop before push: when full, push and pop target the same slot and the push must win.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wa_d[wr_ptr_q]    = ld_issue_wa;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-port selection; address and data stay zero on idle cycles for the ungated bypass.
  always_comb begin
    we3_d = 1'b0;
    wa3_d = 5'd0;
    wd3_d = 32'd0;
    if (pipe_eff) begin
      we3_d = 1'b1;
      wa3_d = pipe_wa;
      wd3_d = pipe_wd;
    end else if (pop && (head_wa != 5'd0)) begin
      we3_d = 1'b1;
      wa3_d = head_wa;
      wd3_d = ld_rdata;
    end
  end

  // Hazard against any in-flight load destination; x0 never matches.
  always_comb begin
    lhz_stall = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (valid_q[i] && (wa_q[i] != 5'd0) &&
          ((wa_q[i] == ra1) || (wa_q[i] == ra2) || (wa_q[i] == wa_dec))) begin
        lhz_stall = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the queue storage is reset too, since valid bits drive the stall and reset discards loads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        wa_q[i]    <= 5'd0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= 5'd0;
      wd3_q    <= 32'd0;
    end else begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        wa_q[i]    <= wa_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

endmodule

// File: tb/tb_nf_wb_arbiter.sv
// Bench for nf_wb_arbiter: a queue-based reference model checked every cycle on the falling
// edge, plus directed scenarios with literal expectations taken after the rising edge.
module tb_nf_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_we;
  logic        ld_issue;
  logic [4:0]  ld_issue_wa;
  logic        ld_issue_rdy;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_rready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa_dec;
  logic        lhz_stall;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        we3;

  nf_wb_arbiter #(.LD_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_we(pipe_we),
    .ld_issue(ld_issue), .ld_issue_wa(ld_issue_wa), .ld_issue_rdy(ld_issue_rdy),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_rready(ld_rready),
    .ra1(ra1), .ra2(ra2), .wa_dec(wa_dec), .lhz_stall(lhz_stall),
    .wa3(wa3), .wd3(wd3), .we3(we3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model: outstanding load destinations in issue order, plus expected write port.
  logic [4:0]  mq[$];
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic mdl_eff();
    return pipe_we && (pipe_wa != 5'd0);
  endfunction

  function automatic logic mdl_rready();
    if (mq.size() == 0) return 1'b0;
    return !mdl_eff() || (mq[0] == 5'd0);
  endfunction

  function automatic logic mdl_stall();
    foreach (mq[i])
      if (mq[i] != 5'd0 && (mq[i] == ra1 || mq[i] == ra2 || mq[i] == wa_dec)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mdl_rdy();
    return mq.size() < DEPTH;
  endfunction

  task automatic mdl_clear();
    mq.delete();
    exp_we = 1'b0;
    exp_wa = 5'd0;
    exp_wd = 32'd0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ld_issue_rdy", ld_issue_rdy, mdl_rdy());
      check("ld_rready", ld_rready, mdl_rready());
      check("lhz_stall", lhz_stall, mdl_stall());
      check("we3", we3, exp_we);
      check("wa3", wa3, exp_wa);
      check("wd3", wd3, exp_wd);
    end
  end

  // One clock: advance the model from the inputs seen at the edge, then settle.
  task automatic tick();
    logic pop;
    logic push;
    logic [4:0] head;
    @(posedge clk);
    if (!resetn) begin
      mdl_clear();
    end else begin
      head = (mq.size() != 0) ? mq[0] : 5'd0;
      pop  = ld_rvalid && mdl_rready();
      push = ld_issue && (mdl_rdy() || pop);
      if (mdl_eff()) begin
        exp_we = 1'b1; exp_wa = pipe_wa; exp_wd = pipe_wd;
      end else if (pop && head != 5'd0) begin
        exp_we = 1'b1; exp_wa = head; exp_wd = ld_rdata;
      end else begin
        exp_we = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ld_issue_wa);
    end
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
    ld_issue = 1'b0; ld_issue_wa = 5'd0;
    ld_rvalid = 1'b0; ld_rdata = 32'd0;
    ra1 = 5'd0; ra2 = 5'd0; wa_dec = 5'd0;
  endtask

  initial begin
    idle();
    mdl_clear();
    tick();
    tick();
    check("rst_ld_issue_rdy", ld_issue_rdy, 32'd1);
    check("rst_ld_rready", ld_rready, 32'd0);
    check("rst_lhz_stall", lhz_stall, 32'd0);
    check("rst_we3", we3, 32'd0);
    check("rst_wa3", wa3, 32'd0);
    check("rst_wd3", wd3, 32'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Pipeline write: one-cycle latency, then idle zeros.
    pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'hDEAD_BEEF;
    tick();
    check("pipe_we3", we3, 32'd1);
    check("pipe_wa3", wa3, 32'd5);
    check("pipe_wd3", wd3, 32'hDEAD_BEEF);
    idle();
    tick();
    check("idle_we3", we3, 32'd0);
    check("idle_wa3", wa3, 32'd0);

    // Load to x7 stalls a reader of x7 until it returns.
    ld_issue = 1'b1; ld_issue_wa = 5'd7;
    tick();
    ld_issue = 1'b0; ra1 = 5'd7;
    #1 check("ld7_stall", lhz_stall, 32'd1);
    ld_rvalid = 1'b1; ld_rdata = 32'h1234;
    #1 check("ld7_rready", ld_rready, 32'd1);
    tick();
    ld_rvalid = 1'b0;
    #1;
    check("ld7_we3", we3, 32'd1);
    check("ld7_wa3", wa3, 32'd7);
    check("ld7_wd3", wd3, 32'h1234);
    check("ld7_stall_drop", lhz_stall, 32'd0);
    idle();

    // Load return collides with a pipeline write: pipeline first, load next cycle.
    ld_issue = 1'b1; ld_issue_wa = 5'd9;
    tick();
    ld_issue = 1'b0;
    ld_rvalid = 1'b1; ld_rdata = 32'hAAAA;
    pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h3333;
    #1 check("clash_rready", ld_rready, 32'd0);
    tick();
    pipe_we = 1'b0;
    #1;
    check("clash_pipe_wa3", wa3, 32'd3);
    check("clash_pipe_wd3", wd3, 32'h3333);
    check("clash_rready_after", ld_rready, 32'd1);
    tick();
    ld_rvalid = 1'b0;
    #1;
    check("clash_ld_wa3", wa3, 32'd9);
    check("clash_ld_wd3", wd3, 32'hAAAA);
    idle();

    // Fill the queue, try an ignored issue, then issue and return together while full.
    ld_issue = 1'b1; ld_issue_wa = 5'd10;
    tick();
    ld_issue_wa = 5'd11;
    tick();
    ld_issue_wa = 5'd12;
    #1 check("full_rdy", ld_issue_rdy, 32'd0);
    tick();
    ld_issue_wa = 5'd13;
    ld_rvalid = 1'b1; ld_rdata = 32'h10;
    tick();
    ld_issue = 1'b0;
    check("swap_wa3", wa3, 32'd10);
    check("swap_wd3", wd3, 32'h10);
    check("swap_still_full", ld_issue_rdy, 32'd0);
    ld_rvalid = 1'b0;
    ra2 = 5'd12;
    #1 check("ignored_no_stall", lhz_stall, 32'd0);
    wa_dec = 5'd13;
    #1 check("swapped_in_stall", lhz_stall, 32'd1);
    ld_rvalid = 1'b1; ld_rdata = 32'h11;
    tick();
    check("drain11_wa3", wa3, 32'd11);
    ld_rdata = 32'h13;
    tick();
    check("drain13_wa3", wa3, 32'd13);
    check("drain13_wd3", wd3, 32'h13);
    tick();
    check("empty_rvalid_we3", we3, 32'd0);
    check("empty_rvalid_rready", ld_rready, 32'd0);
    idle();

    // x0: load and pipeline writes to x0 never write and never stall.
    ld_issue = 1'b1; ld_issue_wa = 5'd0; ra1 = 5'd0;
    #1 check("x0_stall_pre", lhz_stall, 32'd0);
    tick();
    ld_issue = 1'b0;
    pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hFFFF;
    ld_rvalid = 1'b1; ld_rdata = 32'h55;
    #1;
    check("x0_rready", ld_rready, 32'd1);
    check("x0_stall", lhz_stall, 32'd0);
    tick();
    idle();
    #1;
    check("x0_we3", we3, 32'd0);
    check("x0_wa3", wa3, 32'd0);
    check("x0_popped", ld_issue_rdy, 32'd1);

    // Async reset with two loads outstanding; a late return must be ignored.
    ld_issue = 1'b1; ld_issue_wa = 5'd20;
    tick();
    ld_issue_wa = 5'd21;
    pipe_we = 1'b1; pipe_wa = 5'd4; pipe_wd = 32'h44;
    tick();
    idle();
    check("pre_rst_we3", we3, 32'd1);
    #1;
    resetn = 1'b0;
    mdl_clear();
    #1;
    check("arst_we3", we3, 32'd0);
    check("arst_rdy", ld_issue_rdy, 32'd1);
    ra1 = 5'd20;
    #1 check("arst_stall", lhz_stall, 32'd0);
    tick();
    resetn = 1'b1;
    ld_rvalid = 1'b1; ld_rdata = 32'hBAD;
    #1 check("late_rready", ld_rready, 32'd0);
    tick();
    check("late_we3", we3, 32'd0);
    idle();
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
